imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter WORD, default 32, meaning instruction address width.
REQ-002 Parameter HALF_WORD, default 16, meaning instruction width.
REQ-003 Parameter PROG_DEPTH, default 512, meaning instruction memory capacity in half-word entries.
REQ-004 Parameter START_ADDR, default 0, meaning first fetch address after a load.
REQ-005 One clock; reset is asynchronous and active-high. Ports clk_i and reset_i follow.
REQ-006 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-007 reset_i  input  1  asynchronous reset, active-high.
REQ-008 load_start_i  input  1  single-cycle request to begin a program load.
REQ-009 load_len_i  input  $clog2(PROG_DEPTH)+1  number of half-words to load; sampled with load_start_i.
REQ-010 load_valid_i  input  1  load_data_i holds a valid half-word.
REQ-011 load_data_i  input  HALF_WORD  program half-word.
REQ-012 load_ready_o  output  1  block accepts load_data_i this cycle.
REQ-013 halt_i  input  1  stop fetching and return to IDLE.
REQ-014 stall_i  input  1  hold the current fetch address.
REQ-015 branch_taken_i  input  1  redirect fetch.
REQ-016 branch_target_i  input  WORD  redirect address, in half-word index units.
REQ-017 program_mem_write_en_o  output  1  instruction memory write strobe.
REQ-018 instruction_o  output  HALF_WORD  write data to instruction memory.
REQ-019 instruction_addr_o  output  WORD  write or fetch address to instruction memory.
REQ-020 is_valid_o  output  1  the current fetch address carries a real instruction.
REQ-021 running_o  output  1  high while the state is RUN.
REQ-022 load_done_o  output  1  one-cycle pulse when a load completes.
REQ-023 load_err_o  output  1  one-cycle pulse when a load request is rejected.

Function
REQ-024 The FSM SHALL have exactly four states: IDLE, LOAD, RUN and END.
REQ-025 In IDLE, a load_start_i with 1 <= load_len_i <= PROG_DEPTH SHALL do all of the following:
- latch load_len_i as prog_len;
- clear the write counter wcnt to 0;
- enter LOAD on the next cycle.
REQ-026 In IDLE, a load_start_i with load_len_i = 0 or load_len_i > PROG_DEPTH SHALL pulse load_err_o in the next cycle and remain in IDLE.
REQ-027 In LOAD, load_ready_o SHALL be 1; in every other state it SHALL be 0.
REQ-028 A LOAD handshake (load_valid_i & load_ready_o) SHALL drive, combinationally in the same cycle:
- program_mem_write_en_o = 1;
- instruction_o = load_data_i;
- instruction_addr_o = wcnt.
On the next edge, wcnt SHALL increment.
REQ-029 When load_valid_i is 0 in LOAD, program_mem_write_en_o SHALL be 0 and wcnt SHALL hold; the block SHALL impose no timeout.
REQ-030 The handshake with wcnt = prog_len-1 SHALL cause, on the next cycle:
- state = RUN;
- pc = START_ADDR;
- load_done_o = 1 for that one cycle.
REQ-031 Outside LOAD handshakes, program_mem_write_en_o SHALL be 0 and instruction_addr_o SHALL equal pc.
REQ-032 In RUN, is_valid_o SHALL be 1 iff pc < prog_len. In all other states, is_valid_o SHALL be 0.
REQ-033 In RUN, the next value of pc SHALL be chosen by priority:
- halt_i: state -> IDLE, pc holds;
- else branch_taken_i: pc <= branch_target_i;
- else stall_i: pc holds;
- else: pc <= pc+1.
REQ-034 In RUN, when pc+1 would equal prog_len and no branch, stall or halt is asserted, the state SHALL become END with pc = prog_len.
REQ-035 A branch to a target >= prog_len SHALL enter END on the next cycle.
REQ-036 In END:
- pc SHALL hold;
- branch_taken_i with branch_target_i < prog_len SHALL return to RUN with pc = target;
- halt_i SHALL return to IDLE.
REQ-037 load_start_i SHALL be ignored outside IDLE, with no error pulse.
REQ-038 The pc increment SHALL wrap modulo 2^WORD.
REQ-039 halt_i asserted in LOAD SHALL abort the load:
- state -> IDLE;
- no load_done_o pulse;
- memory contents already written are left as they are.

Reset
REQ-040 While reset_i is high, independent of clk_i, the block SHALL hold:
- state = IDLE;
- pc = START_ADDR;
- wcnt = 0;
- prog_len = 0;
- all outputs at 0.
REQ-041 Assertion of reset_i during LOAD or RUN SHALL discard the in-progress operation. After deassertion, the block SHALL require a new load_start_i.

Verification
REQ-042 load_start_i with len 4, then 4 back-to-back valid words 0xA000..0xA003 -> writes at addresses 0..3, load_done_o pulses, running_o=1, is_valid_o=1 with addresses 0,1,2,3, then END with is_valid_o=0.
REQ-043 len 3 with load_valid_i gaps of 2 idle cycles -> exactly 3 write strobes at addresses 0,1,2, with wcnt held during gaps.
REQ-044 load_start_i with len 0 and, separately, len PROG_DEPTH+1 -> load_err_o pulses once each, state stays IDLE, no writes.
REQ-045 RUN with stall_i and branch_taken_i (target 1) both high at pc=2 -> next address 1; stall_i alone for 3 cycles -> address held 3 cycles with is_valid_o=1.
REQ-046 Branch to target 7 with prog_len 4 -> END, is_valid_o=0; then branch to 0 -> RUN with pc=0.
REQ-047 reset_i pulsed mid-LOAD after 2 of 4 words -> all outputs 0 immediately; a following load_start_i with len 2 completes normally.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: loads a program into instruction memory, then sequences
// fetch addresses with halt/branch/stall control until the program ends.
module imem_fetch_ctrl #(
    parameter int WORD       = 32,
    parameter int HALF_WORD  = 16,
    parameter int PROG_DEPTH = 512,
    parameter int START_ADDR = 0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          load_start_i,
    input  logic [$clog2(PROG_DEPTH):0]   load_len_i,
    input  logic                          load_valid_i,
    input  logic [HALF_WORD-1:0]          load_data_i,
    output logic                          load_ready_o,
    input  logic                          halt_i,
    input  logic                          stall_i,
    input  logic                          branch_taken_i,
    input  logic [WORD-1:0]               branch_target_i,
    output logic                          program_mem_write_en_o,
    output logic [HALF_WORD-1:0]          instruction_o,
    output logic [WORD-1:0]               instruction_addr_o,
    output logic                          is_valid_o,
    output logic                          running_o,
    output logic                          load_done_o,
    output logic                          load_err_o
);
    localparam int LW = $clog2(PROG_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, END} state_t;

    state_t          r_state;
    logic [WORD-1:0] r_pc;
    logic [LW-1:0]   r_wcnt;
    logic [LW-1:0]   r_prog_len;
    logic            r_load_done;
    logic            r_load_err;

    logic            w_hs;
    logic            w_len_ok;
    logic            w_tgt_ok;
    logic            w_last;
    logic [WORD-1:0] w_len_ext;
    logic [WORD-1:0] w_pc_inc;

    assign w_hs      = (r_state == LOAD) && load_valid_i;
    assign w_len_ok  = (load_len_i != '0) && (load_len_i <= LW'(PROG_DEPTH));
    assign w_len_ext = WORD'(r_prog_len);
    assign w_tgt_ok  = branch_target_i < w_len_ext;
    assign w_last    = r_wcnt == (r_prog_len - LW'(1));
    assign w_pc_inc  = r_pc + WORD'(1);

    assign load_ready_o           = r_state == LOAD;
    assign program_mem_write_en_o = w_hs;
    assign instruction_o          = w_hs ? load_data_i : '0;
    assign instruction_addr_o     = w_hs ? WORD'(r_wcnt) : r_pc;
    assign is_valid_o             = (r_state == RUN) && (r_pc < w_len_ext);
    assign running_o              = r_state == RUN;
    assign load_done_o            = r_load_done;
    assign load_err_o             = r_load_err;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= IDLE;
            r_pc        <= WORD'(START_ADDR);
            r_wcnt      <= '0;
            r_prog_len  <= '0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            case (r_state)
                IDLE: if (load_start_i) begin
                    if (w_len_ok) begin
                        r_prog_len <= load_len_i;
                        r_wcnt     <= '0;
                        r_state    <= LOAD;
                    end else begin
                        r_load_err <= 1'b1;
                    end
                end
                LOAD: if (halt_i) begin
                    r_state <= IDLE;
                end else if (load_valid_i) begin
                    r_wcnt <= r_wcnt + LW'(1);
                    if (w_last) begin
                        r_state     <= RUN;
                        r_pc        <= WORD'(START_ADDR);
                        r_load_done <= 1'b1;
                    end
                end
                RUN: if (halt_i) begin
                    r_state <= IDLE;
                end else if (branch_taken_i) begin
                    r_pc    <= branch_target_i;
                    r_state <= w_tgt_ok ? RUN : END;
                end else if (!stall_i) begin
                    r_pc <= w_pc_inc;
                    if (w_pc_inc == w_len_ext) r_state <= END;
                end
                END: if (halt_i) begin
                    r_state <= IDLE;
                end else if (branch_taken_i && w_tgt_ok) begin
                    r_pc    <= branch_target_i;
                    r_state <= RUN;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed scenario tasks with hand-computed expectations.
module tb_imem_fetch_ctrl;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        load_start_i;
    logic [9:0]  load_len_i;
    logic        load_valid_i;
    logic [15:0] load_data_i;
    logic        load_ready_o;
    logic        halt_i;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        program_mem_write_en_o;
    logic [15:0] instruction_o;
    logic [31:0] instruction_addr_o;
    logic        is_valid_o;
    logic        running_o;
    logic        load_done_o;
    logic        load_err_o;
    logic [53:0] w_outs;

    int tests = 0;
    int fails = 0;

    imem_fetch_ctrl dut (
        .clk_i(clk_i), .reset_i(reset_i), .load_start_i(load_start_i), .load_len_i(load_len_i),
        .load_valid_i(load_valid_i), .load_data_i(load_data_i), .load_ready_o(load_ready_o),
        .halt_i(halt_i), .stall_i(stall_i), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i), .program_mem_write_en_o(program_mem_write_en_o),
        .instruction_o(instruction_o), .instruction_addr_o(instruction_addr_o),
        .is_valid_o(is_valid_o), .running_o(running_o), .load_done_o(load_done_o),
        .load_err_o(load_err_o)
    );

    assign w_outs = {load_ready_o, program_mem_write_en_o, instruction_o, instruction_addr_o,
                     is_valid_o, running_o, load_done_o, load_err_o};

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_load(input int len, input logic [15:0] base);
        load_start_i = 1'b1;
        load_len_i   = 10'(len);
        tick;
        load_start_i = 1'b0;
        for (int i = 0; i < len; i++) begin
            load_valid_i = 1'b1;
            load_data_i  = base + 16'(i);
            tick;
        end
        load_valid_i = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        #3;
        tests++;
        if (w_outs !== '0) begin
            fails++;
            $display("FAIL reset_outs got %0h want 0", w_outs);
        end
        #1 reset_i = 1'b0;
        tick;
        tests++;
        if (running_o !== 1'b0 || load_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle got run=%b rdy=%b want 0 0", running_o, load_ready_o);
        end
    endtask

    task automatic test_load_run;
        load_start_i = 1'b1;
        load_len_i   = 10'd4;
        tick;
        load_start_i = 1'b0;
        #1;
        tests++;
        if (load_ready_o !== 1'b1 || running_o !== 1'b0) begin
            fails++;
            $display("FAIL load_enter got rdy=%b run=%b want 1 0", load_ready_o, running_o);
        end
        for (int i = 0; i < 4; i++) begin
            load_valid_i = 1'b1;
            load_data_i  = 16'hA000 + 16'(i);
            #1;
            tests++;
            if (program_mem_write_en_o !== 1'b1 || instruction_addr_o !== 32'(i)
                || instruction_o !== 16'hA000 + 16'(i)) begin
                fails++;
                $display("FAIL load_write%0d got we=%b addr=%0h data=%0h want 1 %0h %0h", i,
                         program_mem_write_en_o, instruction_addr_o, instruction_o, i, 16'hA000 + 16'(i));
            end
            tick;
        end
        load_valid_i = 1'b0;
        #1;
        tests++;
        if (load_done_o !== 1'b1 || running_o !== 1'b1 || is_valid_o !== 1'b1
            || instruction_addr_o !== 32'd0 || program_mem_write_en_o !== 1'b0) begin
            fails++;
            $display("FAIL load_done got done=%b run=%b vld=%b addr=%0h we=%b want 1 1 1 0 0",
                     load_done_o, running_o, is_valid_o, instruction_addr_o, program_mem_write_en_o);
        end
        for (int i = 1; i < 4; i++) begin
            tick;
            tests++;
            if (instruction_addr_o !== 32'(i) || is_valid_o !== 1'b1 || load_done_o !== 1'b0) begin
                fails++;
                $display("FAIL run_seq%0d got addr=%0h vld=%b done=%b want %0h 1 0", i,
                         instruction_addr_o, is_valid_o, load_done_o, i);
            end
        end
        tick;
        tests++;
        if (running_o !== 1'b0 || is_valid_o !== 1'b0 || instruction_addr_o !== 32'd4) begin
            fails++;
            $display("FAIL run_end got run=%b vld=%b addr=%0h want 0 0 4",
                     running_o, is_valid_o, instruction_addr_o);
        end
        halt_i = 1'b1;
        tick;
        halt_i = 1'b0;
    endtask

    task automatic test_gaps;
        int strobes = 0;
        int exp     = 0;
        load_start_i = 1'b1;
        load_len_i   = 10'd3;
        tick;
        load_start_i = 1'b0;
        for (int c = 0; c < 7; c++) begin
            load_valid_i = (c % 3) == 0;
            load_data_i  = 16'hB000 + 16'(c);
            #1;
            if (program_mem_write_en_o === 1'b1) strobes++;
            tests++;
            if (load_valid_i) begin
                if (program_mem_write_en_o !== 1'b1 || instruction_addr_o !== 32'(exp)) begin
                    fails++;
                    $display("FAIL gap_write%0d got we=%b addr=%0h want 1 %0h", c,
                             program_mem_write_en_o, instruction_addr_o, exp);
                end
                exp++;
            end else if (program_mem_write_en_o !== 1'b0) begin
                fails++;
                $display("FAIL gap_idle%0d got we=%b want 0", c, program_mem_write_en_o);
            end
            tick;
        end
        load_valid_i = 1'b0;
        #1;
        tests++;
        if (strobes != 3 || load_done_o !== 1'b1 || running_o !== 1'b1) begin
            fails++;
            $display("FAIL gap_done got strobes=%0d done=%b run=%b want 3 1 1",
                     strobes, load_done_o, running_o);
        end
        halt_i = 1'b1;
        tick;
        halt_i = 1'b0;
    endtask

    task automatic test_err;
        int lens[2] = '{0, 513};
        foreach (lens[k]) begin
            load_start_i = 1'b1;
            load_len_i   = 10'(lens[k]);
            tick;
            load_start_i = 1'b0;
            #1;
            tests++;
            if (load_err_o !== 1'b1 || load_ready_o !== 1'b0 || program_mem_write_en_o !== 1'b0) begin
                fails++;
                $display("FAIL err_pulse len=%0d got err=%b rdy=%b we=%b want 1 0 0",
                         lens[k], load_err_o, load_ready_o, program_mem_write_en_o);
            end
            tick;
            tests++;
            if (load_err_o !== 1'b0 || load_ready_o !== 1'b0 || running_o !== 1'b0) begin
                fails++;
                $display("FAIL err_once len=%0d got err=%b rdy=%b run=%b want 0 0 0",
                         lens[k], load_err_o, load_ready_o, running_o);
            end
        end
    endtask

    task automatic test_stall_branch;
        do_load(4, 16'hC000);
        tick;
        tick;
        tests++;
        if (instruction_addr_o !== 32'd2) begin
            fails++;
            $display("FAIL sb_pc2 got %0h want 2", instruction_addr_o);
        end
        stall_i         = 1'b1;
        branch_taken_i  = 1'b1;
        branch_target_i = 32'd1;
        tick;
        branch_taken_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick;
            tests++;
            if (instruction_addr_o !== 32'd1 || is_valid_o !== 1'b1) begin
                fails++;
                $display("FAIL sb_hold%0d got addr=%0h vld=%b want 1 1", k,
                         instruction_addr_o, is_valid_o);
            end
        end
        stall_i = 1'b0;
        tick;
        tests++;
        if (instruction_addr_o !== 32'd2) begin
            fails++;
            $display("FAIL sb_resume got %0h want 2", instruction_addr_o);
        end
    endtask

    task automatic test_branch_end;
        load_start_i    = 1'b1;
        load_len_i      = 10'd0;
        branch_taken_i  = 1'b1;
        branch_target_i = 32'd7;
        tick;
        branch_taken_i = 1'b0;
        load_start_i   = 1'b0;
        tests++;
        if (running_o !== 1'b0 || is_valid_o !== 1'b0 || instruction_addr_o !== 32'd7
            || load_err_o !== 1'b0) begin
            fails++;
            $display("FAIL br_end got run=%b vld=%b addr=%0h err=%b want 0 0 7 0",
                     running_o, is_valid_o, instruction_addr_o, load_err_o);
        end
        tick;
        tests++;
        if (instruction_addr_o !== 32'd7 || running_o !== 1'b0) begin
            fails++;
            $display("FAIL br_end_hold got addr=%0h run=%b want 7 0", instruction_addr_o, running_o);
        end
        branch_taken_i  = 1'b1;
        branch_target_i = 32'd0;
        tick;
        branch_taken_i = 1'b0;
        tests++;
        if (running_o !== 1'b1 || is_valid_o !== 1'b1 || instruction_addr_o !== 32'd0) begin
            fails++;
            $display("FAIL br_back got run=%b vld=%b addr=%0h want 1 1 0",
                     running_o, is_valid_o, instruction_addr_o);
        end
        halt_i = 1'b1;
        tick;
        halt_i = 1'b0;
        tests++;
        if (running_o !== 1'b0 || load_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL br_halt got run=%b rdy=%b want 0 0", running_o, load_ready_o);
        end
    endtask

    task automatic test_reset_mid_load;
        load_start_i = 1'b1;
        load_len_i   = 10'd3;
        tick;
        load_start_i = 1'b0;
        load_valid_i = 1'b1;
        load_data_i  = 16'hE000;
        tick;
        load_valid_i = 1'b0;
        halt_i       = 1'b1;
        tick;
        halt_i = 1'b0;
        tick;
        tests++;
        if (load_ready_o !== 1'b0 || load_done_o !== 1'b0 || running_o !== 1'b0) begin
            fails++;
            $display("FAIL halt_abort got rdy=%b done=%b run=%b want 0 0 0",
                     load_ready_o, load_done_o, running_o);
        end
        load_start_i = 1'b1;
        load_len_i   = 10'd4;
        tick;
        load_start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid_i = 1'b1;
            load_data_i  = 16'hF000 + 16'(i);
            tick;
        end
        load_valid_i = 1'b0;
        #1;
        tests++;
        if (load_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL mid_load got rdy=%b want 1", load_ready_o);
        end
        reset_i = 1'b1;
        #1;
        tests++;
        if (w_outs !== '0) begin
            fails++;
            $display("FAIL mid_reset got %0h want 0", w_outs);
        end
        tick;
        reset_i = 1'b0;
        do_load(2, 16'hD000);
        tests++;
        if (load_done_o !== 1'b1 || running_o !== 1'b1 || instruction_addr_o !== 32'd0) begin
            fails++;
            $display("FAIL reload_done got done=%b run=%b addr=%0h want 1 1 0",
                     load_done_o, running_o, instruction_addr_o);
        end
        tick;
        tick;
        tests++;
        if (running_o !== 1'b0 || is_valid_o !== 1'b0 || instruction_addr_o !== 32'd2) begin
            fails++;
            $display("FAIL reload_end got run=%b vld=%b addr=%0h want 0 0 2",
                     running_o, is_valid_o, instruction_addr_o);
        end
    endtask

    initial begin
        reset_i         = 1'b1;
        load_start_i    = 1'b0;
        load_len_i      = '0;
        load_valid_i    = 1'b0;
        load_data_i     = '0;
        halt_i          = 1'b0;
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = '0;
        test_reset;
        test_load_run;
        test_gaps;
        test_err;
        test_stall_branch;
        test_branch_end;
        test_reset_mid_load;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
